// File: rtl/nested_loop_pkg.sv
// Shared types and helpers for the nested initiation-interval loop counter.
package nested_loop_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // Width needed to count 0..II inclusive.
  function automatic int ii_cnt_w(input int ii);
    return $clog2(ii + 1);
  endfunction

  // Bit offset of dimension d inside a flat DIMS*W vector.
  function automatic int slice_lo(input int d, input int w);
    return d * w;
  endfunction

endpackage

// File: rtl/loop_dim_counter.sv
// One loop dimension: holds its index, wraps at trip-1 and carries outward.
module loop_dim_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] trip,
  output logic [W-1:0] idx,
  output logic         at_max,
  output logic         wrap
);

  logic [W-1:0] idx_q;

  // A (re)start issues iteration 0 this cycle, so the visible index is forced
  // to zero and any advance is taken from that base.
  assign idx    = clear ? '0 : idx_q;
  assign at_max = (idx == trip - W'(1));
  assign wrap   = inc & at_max;

  always_ff @(posedge clk) begin
    if (rst)        idx_q <= '0;
    else if (inc)   idx_q <= at_max ? '0 : idx + W'(1);
    else if (clear) idx_q <= '0;
  end

endmodule

// File: rtl/nested_ii_loop_counter.sv
// DIMS-deep loop nest issued at a fixed initiation interval, gated by en.
// Optional perf counters enabled by defining NESTED_LOOP_PERF_EN.
module nested_ii_loop_counter
  import nested_loop_pkg::*;
#(
  parameter int DIMS = 2,
  parameter int W    = 32,
  parameter int II   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [DIMS*W-1:0] trip_counts,
  output logic              fire,
  output logic [DIMS*W-1:0] idx,
  output logic              last,
  output logic              busy,
  output logic              done
`ifdef NESTED_LOOP_PERF_EN
  ,
  output logic [W-1:0]      perf_iters,
  output logic [W-1:0]      perf_stalls
`endif
);

  localparam int CW = ii_cnt_w(II);

  state_t            state_q, state_d;
  logic [CW-1:0]     ii_cnt;
  logic [DIMS*W-1:0] trip_q, trip_eff;
  logic [DIMS-1:0]   at_max, wrap, carry, trip_zero;
  logic              start_ok, run_fire, nest_end;

  assign busy     = (state_q == RUN);
  assign trip_eff = start ? trip_counts : trip_q;
  assign start_ok = start & ~|trip_zero;
  assign run_fire = busy & en & (ii_cnt == CW'(II - 1));
  // start overrides whatever the running nest was about to do.
  assign fire     = start ? start_ok : run_fire;
  assign last     = fire & (&at_max);
  assign nest_end = wrap[DIMS-1];
  assign done     = (start & ~start_ok) | last;

  for (genvar d = 0; d < DIMS; d++) begin : g_dim
    localparam int LO = slice_lo(d, W);

    assign trip_zero[d] = (trip_counts[LO +: W] == '0);
    if (d == 0) begin : g_c0
      assign carry[d] = fire;
    end else begin : g_cn
      assign carry[d] = wrap[d-1];
    end

    loop_dim_counter #(.W(W)) u_dim (
      .clk    (clk),
      .rst    (rst),
      .clear  (start),
      .inc    (carry[d]),
      .trip   (trip_eff[LO +: W]),
      .idx    (idx[LO +: W]),
      .at_max (at_max[d]),
      .wrap   (wrap[d])
    );
  end

  always_comb begin
    state_d = state_q;
    if (start)                    state_d = (start_ok & ~nest_end) ? RUN : IDLE;
    else if (run_fire & nest_end) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ii_cnt  <= '0;
      trip_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        trip_q <= trip_counts;
        ii_cnt <= '0;
      end else if (busy & en) begin
        ii_cnt <= (ii_cnt == CW'(II - 1)) ? '0 : ii_cnt + 1'b1;
      end
    end
  end

`ifdef NESTED_LOOP_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_iters  <= '0;
      perf_stalls <= '0;
    end else if (start) begin
      perf_iters  <= {{(W-1){1'b0}}, start_ok};
      perf_stalls <= '0;
    end else begin
      if (fire && !(&perf_iters))           perf_iters  <= perf_iters + 1'b1;
      if (busy && !en && !(&perf_stalls))   perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nested_ii_loop_counter.sv
// Directed bench: expected fires queued at stimulus time, compared as the DUT fires.
module tb_nested_ii_loop_counter;

  localparam int W    = 8;
  localparam int DIMS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // u1: II=1, u2: II=2
  logic              start1 = 0, en1 = 0, start2 = 0, en2 = 0;
  logic [DIMS*W-1:0] trips1 = '0, trips2 = '0;
  logic              fire1, last1, busy1, done1, fire2, last2, busy2, done2;
  logic [DIMS*W-1:0] idx1, idx2;
`ifdef NESTED_LOOP_PERF_EN
  logic [W-1:0]      perf_iters1, perf_stalls1, perf_iters2, perf_stalls2;
`endif

  nested_ii_loop_counter #(.DIMS(DIMS), .W(W), .II(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .en(en1), .trip_counts(trips1),
    .fire(fire1), .idx(idx1), .last(last1), .busy(busy1), .done(done1)
`ifdef NESTED_LOOP_PERF_EN
    , .perf_iters(perf_iters1), .perf_stalls(perf_stalls1)
`endif
  );

  nested_ii_loop_counter #(.DIMS(DIMS), .W(W), .II(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .en(en2), .trip_counts(trips2),
    .fire(fire2), .idx(idx2), .last(last2), .busy(busy2), .done(done2)
`ifdef NESTED_LOOP_PERF_EN
    , .perf_iters(perf_iters2), .perf_stalls(perf_stalls2)
`endif
  );

  typedef struct {
    int          c;
    logic [15:0] ix;
    logic        lst;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push1(input int c, input logic [15:0] ix, input logic lst);
    exp_t e;
    e.c = c; e.ix = ix; e.lst = lst;
    q1.push_back(e);
  endtask

  task automatic push2(input int c, input logic [15:0] ix, input logic lst);
    exp_t e;
    e.c = c; e.ix = ix; e.lst = lst;
    q2.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && fire1) begin
      if (q1.size() == 0) check("u1_spurious_fire", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("u1_fire_cycle", cyc, e.c);
        check("u1_idx", {16'd0, idx1}, {16'd0, e.ix});
        check("u1_last", {31'd0, last1}, {31'd0, e.lst});
        check("u1_done", {31'd0, done1}, {31'd0, e.lst});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && fire2) begin
      if (q2.size() == 0) check("u2_spurious_fire", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("u2_fire_cycle", cyc, e.c);
        check("u2_idx", {16'd0, idx2}, {16'd0, e.ix});
        check("u2_last", {31'd0, last2}, {31'd0, e.lst});
        check("u2_done", {31'd0, done2}, {31'd0, e.lst});
      end
    end
  end

  // Position just after the active edge of cycle c.
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Position mid-way through cycle c, clear of the monitors.
  task automatic sample(input int c);
    go(c);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;

    go(3);
    rst = 1'b0;
    sample(3);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    check("rst_fire1", {31'd0, fire1}, 32'd0);
    check("rst_done2", {31'd0, done2}, 32'd0);
    check("rst_idx1", {16'd0, idx1}, 32'd0);

    // II=2, trips (3,2), en always high
    t0 = cyc + 1;
    go(t0);
    trips2 = 16'h0203; start2 = 1; en2 = 1;
    push2(t0 + 0, 16'h0000, 0); push2(t0 + 2, 16'h0001, 0);
    push2(t0 + 4, 16'h0002, 0); push2(t0 + 6, 16'h0100, 0);
    push2(t0 + 8, 16'h0101, 0); push2(t0 + 10, 16'h0102, 1);
    sample(t0);
    check("t1_busy_start", {31'd0, busy2}, 32'd0);
    go(t0 + 1);
    start2 = 0;
    sample(t0 + 1);
    check("t1_busy_run", {31'd0, busy2}, 32'd1);
    sample(t0 + 10);
    check("t1_done_last", {31'd0, done2}, 32'd1);
    sample(t0 + 11);
    check("t1_busy_after", {31'd0, busy2}, 32'd0);
    check("t1_done_after", {31'd0, done2}, 32'd0);

    // Same nest with en low on cycles 3..5
    t0 = cyc + 1;
    go(t0);
    start2 = 1; en2 = 1;
    push2(t0 + 0, 16'h0000, 0); push2(t0 + 2, 16'h0001, 0);
    push2(t0 + 7, 16'h0002, 0); push2(t0 + 9, 16'h0100, 0);
    push2(t0 + 11, 16'h0101, 0); push2(t0 + 13, 16'h0102, 1);
    go(t0 + 1); start2 = 0;
    go(t0 + 3); en2 = 0;
    go(t0 + 6); en2 = 1;
    sample(t0 + 13);
    check("t2_done_last", {31'd0, done2}, 32'd1);
    sample(t0 + 14);
    check("t2_busy_after", {31'd0, busy2}, 32'd0);
`ifdef NESTED_LOOP_PERF_EN
    check("t2_perf_stalls", {24'd0, perf_stalls2}, 32'd3);
    check("t2_perf_iters", {24'd0, perf_iters2}, 32'd6);
`endif

    // II=1, single-iteration nest
    t0 = cyc + 1;
    go(t0);
    trips1 = 16'h0101; start1 = 1; en1 = 1;
    push1(t0, 16'h0000, 1);
    sample(t0);
    check("t3_done", {31'd0, done1}, 32'd1);
    check("t3_busy", {31'd0, busy1}, 32'd0);
    go(t0 + 1); start1 = 0;
    sample(t0 + 3);
    check("t3_busy_later", {31'd0, busy1}, 32'd0);

    // Zero trip count in dim 1
    t0 = cyc + 1;
    go(t0);
    trips1 = 16'h0004; start1 = 1;
    sample(t0);
    check("t4_done", {31'd0, done1}, 32'd1);
    check("t4_fire", {31'd0, fire1}, 32'd0);
    go(t0 + 1); start1 = 0;
    sample(t0 + 1);
    check("t4_busy", {31'd0, busy1}, 32'd0);
    check("t4_done_after", {31'd0, done1}, 32'd0);

    // Restart mid-nest with new trips (2,1)
    t0 = cyc + 1;
    go(t0);
    trips1 = 16'h0203; start1 = 1;
    push1(t0, 16'h0000, 0); push1(t0 + 1, 16'h0001, 0);
    go(t0 + 1); start1 = 0;
    go(t0 + 2);
    trips1 = 16'h0102; start1 = 1;
    push1(t0 + 2, 16'h0000, 0); push1(t0 + 3, 16'h0001, 1);
    sample(t0 + 2);
    check("t5_no_done_restart", {31'd0, done1}, 32'd0);
    go(t0 + 3); start1 = 0;
    sample(t0 + 3);
    check("t5_done", {31'd0, done1}, 32'd1);
    sample(t0 + 4);
    check("t5_busy_after", {31'd0, busy1}, 32'd0);
`ifdef NESTED_LOOP_PERF_EN
    check("t5_perf_iters", {24'd0, perf_iters1}, 32'd2);
`endif

    // Synchronous reset mid-nest
    t0 = cyc + 1;
    go(t0);
    trips1 = 16'h0203; start1 = 1;
    push1(t0, 16'h0000, 0); push1(t0 + 1, 16'h0001, 0); push1(t0 + 2, 16'h0002, 0);
    go(t0 + 1); start1 = 0;
    go(t0 + 3); rst = 1;
    go(t0 + 4); rst = 0;
    sample(t0 + 4);
    check("t6_fire", {31'd0, fire1}, 32'd0);
    check("t6_busy", {31'd0, busy1}, 32'd0);
    check("t6_done", {31'd0, done1}, 32'd0);
    check("t6_idx", {16'd0, idx1}, 32'd0);
    t1 = t0 + 5;
    go(t1);
    trips1 = 16'h0102; start1 = 1;
    push1(t1, 16'h0000, 0); push1(t1 + 1, 16'h0001, 1);
    go(t1 + 1); start1 = 0;
    sample(t1 + 2);
    check("t6_busy_end", {31'd0, busy1}, 32'd0);

    sample(cyc + 2);
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
